// File: rtl/dffq_chain_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dffq_chain_bist_pkg
// Description : Shared state encoding and PRBS7 constants for the flop-chain BIST.
// Revision    : 1.0 - initial release
// ============================================================================
package dffq_chain_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_PRIME = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int              c_PRBS_W     = 7;
    localparam int              c_PRBS_TAP_A = 6;
    localparam int              c_PRBS_TAP_B = 5;
    localparam logic [c_PRBS_W-1:0] c_PRBS_SEED = 7'h7F;

    // x^7 + x^6 + 1, emitted bit is the MSB before the shift
    function automatic logic [c_PRBS_W-1:0] prbs7_next(input logic [c_PRBS_W-1:0] s);
        return {s[c_PRBS_W-2:0], s[c_PRBS_TAP_A] ^ s[c_PRBS_TAP_B]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dffq_chain_stage.sv
`default_nettype none
// ============================================================================
// Module      : dffq_chain_stage
// Description : Single posedge D->Q stage without reset; swap point for the library flop in netlist builds.
// Revision    : 1.0 - initial release
// ============================================================================
module dffq_chain_stage (
    input  logic CLK,
    input  logic D,
    output logic Q
);

    always_ff @(posedge CLK) begin
        Q <= D;
    end

endmodule
`default_nettype wire

// File: rtl/dffq_chain_bist.sv
`default_nettype none
// ============================================================================
// Module      : dffq_chain_bist
// Description : PRBS7 stimulus into a reset-less flop chain with a regenerating checker.
// Revision    : 1.0 - initial release
// ============================================================================
module dffq_chain_bist
    import dffq_chain_bist_pkg::*;
#(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [CNT_W-1:0] NUM_PAT,
    input  logic             INJECT_ERR,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic             CHAIN_Q
);

    localparam int                    c_PCNT_W     = (CHAIN_LEN < 2) ? 1 : $clog2(CHAIN_LEN);
    localparam logic [c_PCNT_W-1:0]   c_PRIME_LAST = c_PCNT_W'(CHAIN_LEN - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_PRBS_W-1:0]   r_gen;
    logic [c_PRBS_W-1:0]   r_chk;
    logic [c_PCNT_W-1:0]   r_pcnt;
    logic [CNT_W-1:0]      r_num_pat;
    logic [CNT_W-1:0]      r_pat_cnt;
    logic [CNT_W-1:0]      r_err_cnt;
    logic [CNT_W-1:0]      w_err_nxt;
    logic                  r_busy, r_done, r_pass;
    logic                  w_busy_nxt, w_done_nxt, w_pass_nxt;
    logic                  w_start_ok, w_prime_end, w_run_end, w_mismatch, w_chain_in;
    logic [CHAIN_LEN-1:0]  w_d;
    logic [CHAIN_LEN-1:0]  w_q;

    assign w_start_ok  = START && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_prime_end = (r_state == ST_PRIME) && (r_pcnt == c_PRIME_LAST);
    assign w_run_end   = (r_state == ST_RUN) && (r_pat_cnt == (r_num_pat - CNT_W'(1)));
    assign w_mismatch  = (r_state == ST_RUN) && (w_q[CHAIN_LEN-1] != r_chk[c_PRBS_W-1]);
    assign w_chain_in  = r_gen[c_PRBS_W-1]
                       ^ (INJECT_ERR && ((r_state == ST_PRIME) || (r_state == ST_RUN)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (START) w_state_nxt = ST_SEED;
            ST_SEED:          w_state_nxt = ST_PRIME;
            ST_PRIME:         if (w_prime_end) w_state_nxt = (r_num_pat == '0) ? ST_DONE : ST_RUN;
            ST_RUN:           if (w_run_end) w_state_nxt = ST_DONE;
            default:          w_state_nxt = ST_IDLE;
        endcase
    end

    // Flags are registered from the next state so they line up with it
    always_comb begin
        w_busy_nxt = (w_state_nxt == ST_SEED) || (w_state_nxt == ST_PRIME) || (w_state_nxt == ST_RUN);
        w_done_nxt = (w_state_nxt == ST_DONE);
        w_pass_nxt = w_done_nxt && (w_err_nxt == '0);
    end

    always_comb begin
        w_err_nxt = r_err_cnt;
        if (w_start_ok) begin
            w_err_nxt = '0;
        end else if (w_mismatch && (r_err_cnt != {CNT_W{1'b1}})) begin
            w_err_nxt = r_err_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_gen     <= c_PRBS_SEED;
            r_chk     <= c_PRBS_SEED;
            r_pcnt    <= '0;
            r_num_pat <= '0;
            r_pat_cnt <= '0;
            r_err_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_err_cnt <= w_err_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_pass    <= w_pass_nxt;
            if (w_start_ok) begin
                r_num_pat <= NUM_PAT;
            end
            case (r_state)
                ST_SEED: begin
                    r_gen     <= c_PRBS_SEED;
                    r_chk     <= c_PRBS_SEED;
                    r_pcnt    <= '0;
                    r_pat_cnt <= '0;
                end
                ST_PRIME: begin
                    r_gen  <= prbs7_next(r_gen);
                    r_pcnt <= r_pcnt + c_PCNT_W'(1);
                end
                ST_RUN: begin
                    r_gen     <= prbs7_next(r_gen);
                    r_chk     <= prbs7_next(r_chk);
                    r_pat_cnt <= r_pat_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Stages carry no reset; zeroing is done on their D inputs
    generate
        for (genvar k = 0; k < CHAIN_LEN; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign w_d[k] = RST ? 1'b0 : w_chain_in;
            end else begin : g_tail
                assign w_d[k] = RST ? 1'b0 : w_q[k-1];
            end
            dffq_chain_stage u_stage (
                .CLK (CLK),
                .D   (w_d[k]),
                .Q   (w_q[k])
            );
        end
    endgenerate

    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign PASS    = r_pass;
    assign ERR_CNT = r_err_cnt;
    assign CHAIN_Q = w_q[CHAIN_LEN-1];

endmodule
`default_nettype wire

// File: doc/dffq_chain_bist.md
Name: dffq_chain_bist

Overview:
- Silicon/gate-level validation block for the 7-track 5V flop cells. A PRBS7 generator drives the D input of a chain of positive-edge D-flop stages with Q-only output and no reset.
- A checker consumes the chain output and compares it against a locally regenerated reference sequence. It counts mismatches.
- Sits as the stimulus source upstream and the response checker downstream of the flop chain under test. Used in test structures and as a regression harness for timing-annotated flop netlists.

Parameters:
- CHAIN_LEN, 8, number of flop stages in the chain under test (>=1).
- CNT_W, 16, width of the pattern-count input and the error counter.

Ports:
- CLK  input  1  single clock; all state updates on its posedge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  one-cycle request to begin a run; ignored unless state is IDLE or DONE.
- NUM_PAT  input  CNT_W  number of bits compared in RUN; sampled in the cycle START is accepted.
- INJECT_ERR  input  1  when high in PRIME or RUN, inverts the bit entering the chain for that cycle.
- BUSY  output  1  high in SEED, PRIME, RUN.
- DONE  output  1  high in DONE state.
- PASS  output  1  DONE && ERR_CNT==0.
- ERR_CNT  output  CNT_W  saturating mismatch count.
- CHAIN_Q  output  1  last chain stage output, for observation.

Behaviour:
- Interface: one clock, CLK; reset is synchronous and active-high, RST. RST has priority over every other input.
- Reset values:
  - state=IDLE.
  - BUSY=0, DONE=0, PASS=0, ERR_CNT=0.
  - Chain stages all 0, so CHAIN_Q=0.
  - Generator and checker LFSRs = 7'h7F.
  - Pattern counter = 0.
- PRBS7 (x^7+x^6+1):
  - new = s[6]^s[5]; s <= {s[5:0],new}.
  - Emitted bit = s[6].
  - Seed 7'h7F gives bits 1,1,1,1,1,1,1,0,...
- Chain: stage0 <= gen[6]^(INJECT_ERR && state in {PRIME,RUN}); stage k <= stage k-1. The chain shifts every cycle regardless of state.
- FSM:
  - IDLE: START -> SEED. Latch NUM_PAT; clear ERR_CNT.
  - SEED (1 cycle): gen=chk=7'h7F -> PRIME.
  - PRIME (exactly CHAIN_LEN cycles): gen advances each cycle; no compare -> RUN. The first generated bit reaches CHAIN_Q in RUN cycle 0.
  - RUN:
    - Each cycle compare CHAIN_Q vs chk[6]; on mismatch ERR_CNT++ (saturate at all-ones).
    - gen and chk both advance.
    - After NUM_PAT compare cycles -> DONE.
    - If NUM_PAT==0, go from PRIME directly to DONE with zero compares.
  - DONE: hold ERR_CNT. START -> SEED (latch NUM_PAT, clear ERR_CNT).
- START while BUSY: ignored; it neither restarts nor queues.
- INJECT_ERR in cycle t of PRIME/RUN produces exactly one mismatch, CHAIN_LEN cycles later, if that cycle falls within RUN. Otherwise it produces none.
- RST mid-run: next cycle IDLE with all reset values; no DONE pulse.
- Outputs are registered; PASS and DONE are valid from the first DONE cycle.

Decomposition:
- Shared package:
  - State enum (IDLE, SEED, PRIME, RUN, DONE).
  - PRBS7 width, tap positions and seed constant 7'h7F.
- Sub-module dffq_chain_stage: a single D->Q posedge register with no reset, instantiated CHAIN_LEN times via generate. Zeroing the chain on RST happens through a reset-gated mux on the stage D input, held in the top level. This lets netlist builds swap in the library flop cell.

Test Plan:
- Reset: RST high 2 cycles -> BUSY=0, DONE=0, PASS=0, ERR_CNT=0, CHAIN_Q=0; START held during RST is ignored.
- Clean run: CHAIN_LEN=8, NUM_PAT=100, START pulse -> BUSY for 1+8+100=109 cycles, then DONE=1, ERR_CNT=0, PASS=1. CHAIN_Q reads 1,1,1,1,1,1,1,0 over RUN cycles 0-7.
- Injection: INJECT_ERR pulsed in RUN cycle 5 and 20 -> ERR_CNT=2, PASS=0. An injection in the last PRIME cycle counts; one within the final 8 RUN cycles does not.
- Boundaries:
  - NUM_PAT=0 -> DONE after 9 BUSY cycles, ERR_CNT=0, PASS=1.
  - CNT_W=4 with INJECT_ERR held high for all of RUN (NUM_PAT=30) -> ERR_CNT saturates at 15.
- START during RUN ignored (run length unchanged). START in DONE with NUM_PAT=10 -> ERR_CNT cleared, new run completes in 19 BUSY cycles.
- RST asserted mid-RUN -> next cycle IDLE, ERR_CNT=0, chain zero. A subsequent clean run passes.
